// File: rtl/two_reg_fifo_pkg.sv
// Shared types and constants for the two-entry register FIFO.
// Valid encodings for the head/tail slot pair.
package two_reg_fifo_pkg;
  localparam int DEPTH = 2;

  typedef logic [1:0] vld_t;

  localparam vld_t VLD_EMPTY = 2'b00;
  localparam vld_t VLD_ONE   = 2'b01;
  localparam vld_t VLD_FULL  = 2'b11;
endpackage

// File: rtl/two_reg_fifo_slot.sv
// One FIFO storage slot: data register plus valid bit.
// Load sets valid; clear drops valid but keeps the data.
module two_reg_fifo_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (ld) begin
      q   <= d;
      vld <= 1'b1;
    end else if (clr) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/two_reg_fifo.sv
// Two-entry first-word fall-through FIFO built from two register slots.
// Define TWO_REG_FIFO_ASSERT_EN to enable overflow/underflow/state assertions.
module two_reg_fifo
  import two_reg_fifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iWrEn,
  input  logic [WIDTH-1:0] iWrDat,
  input  logic             iRdEn,
  output logic             oFul,
  output logic             oEmpty,
  output logic [1:0]       oDatVld,
  output logic [WIDTH-1:0] oRdDat
);

  logic             v0, v1;
  logic             ld0, clr0, ld1, clr1;
  logic [WIDTH-1:0] q0, q1, d0;
  vld_t             vld;

  assign vld = {v1, v0};

  // Full ignores writes; empty ignores reads.
  always_comb begin
    ld0  = 1'b0;
    clr0 = 1'b0;
    ld1  = 1'b0;
    clr1 = 1'b0;
    d0   = iWrDat;
    unique case (vld)
      VLD_EMPTY: ld0 = iWrEn;
      VLD_ONE: begin
        if (iRdEn) begin
          ld0  = iWrEn;
          clr0 = !iWrEn;
        end else begin
          ld1  = iWrEn;
        end
      end
      VLD_FULL: begin
        ld0  = iRdEn;
        d0   = q1;
        clr1 = iRdEn;
      end
      default: ;
    endcase
  end

  two_reg_fifo_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk (clk),
    .rst (rst),
    .ld  (ld0),
    .clr (clr0),
    .d   (d0),
    .q   (q0),
    .vld (v0)
  );

  two_reg_fifo_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk (clk),
    .rst (rst),
    .ld  (ld1),
    .clr (clr1),
    .d   (iWrDat),
    .q   (q1),
    .vld (v1)
  );

  assign oDatVld = vld;
  assign oEmpty  = (vld == VLD_EMPTY);
  assign oFul    = (vld == VLD_FULL);
  assign oRdDat  = q0;

`ifdef TWO_REG_FIFO_ASSERT_EN
  always @(posedge clk) begin
    if (!rst) begin
      a_ovf: assert (!(iWrEn && oFul))
        else $error("two_reg_fifo overflow");
      a_udf: assert (!(iRdEn && oEmpty))
        else $error("two_reg_fifo underflow");
      a_vld: assert (vld != 2'b10)
        else $error("two_reg_fifo illegal valid state");
    end
  end
`endif

endmodule

// File: tb/tb_two_reg_fifo.sv
// Self-checking bench for two_reg_fifo: directed cases plus random
// traffic compared every cycle against a queue-based model.
module tb_two_reg_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iWrEn = 1'b0;
  logic [7:0] iWrDat = '0;
  logic       iRdEn = 1'b0;
  logic       oFul, oEmpty;
  logic [1:0] oDatVld;
  logic [7:0] oRdDat;

  int npass = 0;
  int ntot  = 0;
  bit run   = 1'b0;

  logic [7:0] mq[$];

  two_reg_fifo #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .iWrEn  (iWrEn),
    .iWrDat (iWrDat),
    .iRdEn  (iRdEn),
    .oFul   (oFul),
    .oEmpty (oEmpty),
    .oDatVld(oDatVld),
    .oRdDat (oRdDat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: a queue of at most two entries.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      bit wa, ra;
      wa = iWrEn && (mq.size() < 2);
      ra = iRdEn && (mq.size() > 0);
      if (ra) void'(mq.pop_front());
      if (wa) mq.push_back(iWrDat);
    end
  end

  function automatic logic [1:0] exp_vld();
    if (mq.size() == 0) return 2'b00;
    if (mq.size() == 1) return 2'b01;
    return 2'b11;
  endfunction

  always @(negedge clk) begin
    if (run) begin
      check("cmp_vld", {30'd0, oDatVld}, {30'd0, exp_vld()});
      check("cmp_empty", {31'd0, oEmpty}, {31'd0, mq.size() == 0});
      check("cmp_ful", {31'd0, oFul}, {31'd0, mq.size() == 2});
      if (mq.size() > 0)
        check("cmp_rdat", {24'd0, oRdDat}, {24'd0, mq[0]});
    end
  end

  task automatic op(input bit we, input logic [7:0] wd, input bit re);
    iWrEn  = we;
    iWrDat = wd;
    iRdEn  = re;
    @(posedge clk);
    #1;
    iWrEn = 1'b0;
    iRdEn = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [1:0] v,
                     input logic [7:0] d, input bit chkd);
    check({nm, "_vld"}, {30'd0, oDatVld}, {30'd0, v});
    check({nm, "_empty"}, {31'd0, oEmpty}, {31'd0, v == 2'b00});
    check({nm, "_ful"}, {31'd0, oFul}, {31'd0, v == 2'b11});
    if (chkd) check({nm, "_rdat"}, {24'd0, oRdDat}, {24'd0, d});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    lit("reset", 2'b00, 8'h00, 1'b1);
    rst = 1'b0;
    run = 1'b1;

    op(1, 8'h05, 0);
    lit("single_wr", 2'b01, 8'h05, 1'b1);
    repeat (4) op(0, 8'h00, 0);
    lit("single_hold", 2'b01, 8'h05, 1'b1);
    op(0, 8'h00, 1);
    lit("single_pop", 2'b00, 8'h00, 1'b0);

    op(1, 8'h01, 0);
    op(1, 8'h02, 0);
    lit("fill", 2'b11, 8'h01, 1'b1);
    op(1, 8'h03, 0);
    lit("overflow", 2'b11, 8'h01, 1'b1);
    op(0, 8'h00, 1);
    lit("drain1", 2'b01, 8'h02, 1'b1);
    op(0, 8'h00, 1);
    lit("drain2", 2'b00, 8'h00, 1'b0);

    op(1, 8'h0A, 0);
    op(1, 8'h0B, 1);
    lit("simul_one", 2'b01, 8'h0B, 1'b1);
    op(1, 8'h0C, 0);
    op(1, 8'h0D, 1);
    lit("simul_full", 2'b01, 8'h0C, 1'b1);
    op(0, 8'h00, 1);

    op(0, 8'h00, 1);
    lit("underflow", 2'b00, 8'h00, 1'b0);

    for (int i = 0; i < 500; i++)
      op(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

    while (!oEmpty) op(0, 8'h00, 1);
    op(1, 8'h11, 0);
    op(1, 8'h22, 0);
    lit("pre_rst", 2'b11, 8'h11, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    lit("async_rst", 2'b00, 8'h00, 1'b1);
    op(1, 8'h33, 1);
    lit("rst_ignore", 2'b00, 8'h00, 1'b1);
    rst = 1'b0;
    op(1, 8'h77, 0);
    lit("post_rst_wr", 2'b01, 8'h77, 1'b1);
    op(0, 8'h00, 0);

    run = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
